// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - session sequencer for the Frogger top level
// Drives game start/arm/run/death/game-over flow, scoring, lives and a status read bank.
module game_flow_controller #(
   parameter int unsigned C_LIVES_INI    = 3,
   parameter int unsigned C_DEATH_FRAMES = 60,
   parameter int unsigned C_SCORE_MAX    = 9
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_All_Switch,
   input  logic       i_Any_Switch,
   input  logic       i_Has_Collided,
   input  logic       i_Level_Up,
   input  logic       i_Frame_Tick,
   input  logic       i_read_en,
   input  logic [4:0] i_read_addr,
   output logic [7:0] o_read_data,
   output logic       o_read_valid,
   output logic       o_Game_Active,
   output logic       o_Freeze,
   output logic       o_Respawn,
   output logic [3:0] o_Score,
   output logic [1:0] o_Lives,
   output logic [3:0] o_High_Score,
   output logic       o_Game_Over
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARM       = 3'd1,
      S_RUNNING   = 3'd2,
      S_DYING     = 3'd3,
      S_GAME_OVER = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] score_q, score_d;
   logic [1:0] lives_q, lives_d;
   logic [3:0] high_q, high_d;
   logic [7:0] cnt_q, cnt_d;
   logic       respawn_q, respawn_d;
   logic       active_q, active_d;
   logic       freeze_q, freeze_d;
   logic       over_q, over_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q    <= S_IDLE;
         score_q    <= '0;
         lives_q    <= '0;
         high_q     <= '0;
         cnt_q      <= '0;
         respawn_q  <= 1'b0;
         active_q   <= 1'b0;
         freeze_q   <= 1'b0;
         over_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         score_q    <= score_d;
         lives_q    <= lives_d;
         high_q     <= high_d;
         cnt_q      <= cnt_d;
         respawn_q  <= respawn_d;
         active_q   <= active_d;
         freeze_q   <= freeze_d;
         over_q     <= over_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      lives_d   = lives_q;
      high_d    = high_q;
      cnt_d     = cnt_q;
      respawn_d = 1'b0;

      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (i_All_Switch) begin
               state_d = S_ARM;
               lives_d = 2'(C_LIVES_INI);
               score_d = '0;
            end
         end
         // Movement only starts once every switch is released, so the start chord never moves the frog.
         S_ARM: begin
            if (!i_Any_Switch) begin
               state_d   = S_RUNNING;
               respawn_d = 1'b1;
            end
         end
         S_RUNNING: begin
            if (i_Has_Collided) begin
               state_d = S_DYING;
               cnt_d   = '0;
               if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            end else if (i_Level_Up) begin
               respawn_d = 1'b1;
               if (score_q < 4'(C_SCORE_MAX)) score_d = score_q + 4'd1;
            end
         end
         S_DYING: begin
            if (i_Frame_Tick) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == 8'(C_DEATH_FRAMES)) begin
                  if (lives_q == 2'd0) begin
                     state_d = S_GAME_OVER;
                     if (score_q > high_q) high_d = score_q;
                  end else begin
                     state_d   = S_RUNNING;
                     respawn_d = 1'b1;
                     cnt_d     = '0;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      active_d = (state_d == S_RUNNING);
      freeze_d = (state_d == S_DYING);
      over_d   = (state_d == S_GAME_OVER);
   end

   // Status bank samples pre-edge values, so a read racing an update sees the old contents.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = i_read_en;
      if (i_read_en) begin
         case (i_read_addr)
            5'd0:    rd_data_d = {5'b0, state_q};
            5'd1:    rd_data_d = {4'b0, score_q};
            5'd2:    rd_data_d = {6'b0, lives_q};
            5'd3:    rd_data_d = {4'b0, high_q};
            5'd4:    rd_data_d = cnt_q;
            default: rd_data_d = 8'h00;
         endcase
      end
   end

   assign o_read_data   = rd_data_q;
   assign o_read_valid  = rd_valid_q;
   assign o_Game_Active = active_q;
   assign o_Freeze      = freeze_q;
   assign o_Respawn     = respawn_q;
   assign o_Score       = score_q;
   assign o_Lives       = lives_q;
   assign o_High_Score  = high_q;
   assign o_Game_Over   = over_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - bench for game_flow_controller
module tb_game_flow_controller;

   localparam int LIVES_INI = 3;
   localparam int DEATH     = 60;
   localparam int SMAX      = 9;

   logic       i_Clk = 1'b0;
   logic       i_Rst = 1'b1;
   logic       i_All_Switch = 0, i_Any_Switch = 0, i_Has_Collided = 0;
   logic       i_Level_Up = 0, i_Frame_Tick = 0, i_read_en = 0;
   logic [4:0] i_read_addr = '0;
   logic [7:0] o_read_data;
   logic       o_read_valid, o_Game_Active, o_Freeze, o_Respawn, o_Game_Over;
   logic [3:0] o_Score, o_High_Score;
   logic [1:0] o_Lives;

   always #5 i_Clk = ~i_Clk;

   game_flow_controller dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst),
      .i_All_Switch(i_All_Switch), .i_Any_Switch(i_Any_Switch),
      .i_Has_Collided(i_Has_Collided), .i_Level_Up(i_Level_Up),
      .i_Frame_Tick(i_Frame_Tick), .i_read_en(i_read_en), .i_read_addr(i_read_addr),
      .o_read_data(o_read_data), .o_read_valid(o_read_valid),
      .o_Game_Active(o_Game_Active), .o_Freeze(o_Freeze), .o_Respawn(o_Respawn),
      .o_Score(o_Score), .o_Lives(o_Lives), .o_High_Score(o_High_Score),
      .o_Game_Over(o_Game_Over)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: phase numbers are the externally visible status codes 0..4.
   int m_state, m_score, m_lives, m_hi, m_cnt, m_rd;
   bit m_resp, m_rv;

   function automatic int reg_at(input int a);
      case (a)
         0: return m_state;
         1: return m_score;
         2: return m_lives;
         3: return m_hi;
         4: return m_cnt;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = 0; m_lives = 0; m_hi = 0; m_cnt = 0;
      m_rd = 0; m_rv = 0; m_resp = 0;
   endtask

   task automatic model_step();
      if (i_read_en) m_rd = reg_at(int'(i_read_addr));
      m_rv   = i_read_en;
      m_resp = 0;
      if (m_state == 0 || m_state == 4) begin
         if (i_All_Switch) begin m_state = 1; m_lives = LIVES_INI; m_score = 0; end
      end else if (m_state == 1) begin
         if (!i_Any_Switch) begin m_state = 2; m_resp = 1; end
      end else if (m_state == 2) begin
         if (i_Has_Collided) begin
            m_state = 3; m_cnt = 0;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
         end else if (i_Level_Up) begin
            m_resp = 1;
            m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
         end
      end else if (m_state == 3 && i_Frame_Tick) begin
         m_cnt++;
         if (m_cnt == DEATH) begin
            if (m_lives == 0) begin
               m_state = 4;
               if (m_score > m_hi) m_hi = m_score;
            end else begin
               m_state = 2; m_resp = 1; m_cnt = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [2:0] flags;
      flags = {m_state == 2, m_state == 3, m_state == 4};
      check_eq("score", o_Score, m_score);
      check_eq("lives", o_Lives, m_lives);
      check_eq("high_score", o_High_Score, m_hi);
      check_eq("respawn", o_Respawn, m_resp);
      check_eq("active_freeze_over", {o_Game_Active, o_Freeze, o_Game_Over}, flags);
      check_eq("read_valid", o_read_valid, m_rv);
      check_eq("read_data", o_read_data, m_rd);
   endtask

   task automatic cyc();
      @(posedge i_Clk);
      model_step();
      @(negedge i_Clk);
      compare_all();
      i_All_Switch = 0; i_Any_Switch = 0; i_Has_Collided = 0;
      i_Level_Up = 0; i_Frame_Tick = 0; i_read_en = 0; i_read_addr = '0;
   endtask

   task automatic start_game();
      i_All_Switch = 1; i_Any_Switch = 1; cyc();
      cyc();
      check_eq("start_respawn", o_Respawn, 1);
      check_eq("start_lives", o_Lives, LIVES_INI);
      check_eq("start_active", o_Game_Active, 1);
   endtask

   task automatic level_ups(input int n);
      for (int i = 0; i < n; i++) begin
         i_Level_Up = 1; cyc();
         check_eq("lvl_respawn", o_Respawn, 1);
      end
   endtask

   task automatic die_full();
      i_Has_Collided = 1; cyc();
      for (int i = 0; i < DEATH; i++) begin i_Frame_Tick = 1; cyc(); end
   endtask

   task automatic rd(input int a);
      i_read_en = 1; i_read_addr = 5'(a); cyc();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge i_Clk);
      @(negedge i_Clk);
      compare_all();
      i_Rst = 0;

      // Reset during death freeze with counter at 30
      start_game();
      i_Has_Collided = 1; cyc();
      for (int i = 0; i < 30; i++) begin i_Frame_Tick = 1; cyc(); end
      rd(4);
      check_eq("cnt_30", o_read_data, 30);
      i_Rst = 1;
      #2;
      model_reset();
      compare_all();
      @(negedge i_Clk);
      i_Rst = 0;
      rd(4);
      check_eq("cnt_after_rst", o_read_data, 0);
      rd(0);
      check_eq("state_after_rst", o_read_data, 0);

      // Score 5, simultaneous collision/level-up, death freeze boundary, game over
      start_game();
      level_ups(5);
      i_Has_Collided = 1; i_Level_Up = 1; cyc();
      check_eq("collide_wins_score", o_Score, 5);
      check_eq("collide_lives", o_Lives, 2);
      for (int i = 0; i < DEATH - 1; i++) begin i_Frame_Tick = 1; cyc(); end
      check_eq("freeze_at_59", o_Freeze, 1);
      i_Frame_Tick = 1; cyc();
      check_eq("respawn_at_60", o_Respawn, 1);
      check_eq("running_at_60", o_Game_Active, 1);
      die_full();
      die_full();
      check_eq("game_over", o_Game_Over, 1);
      check_eq("high_5", o_High_Score, 5);

      // Lower-scoring game keeps the previous high score
      start_game();
      level_ups(3);
      repeat (3) die_full();
      check_eq("high_kept", o_High_Score, 5);

      // Status reads and score saturation
      start_game();
      level_ups(7);
      rd(1);
      check_eq("rd_score7", o_read_data, 8'h07);
      check_eq("rd_valid", o_read_valid, 1);
      cyc();
      check_eq("rd_valid_drop", o_read_valid, 0);
      rd(17);
      check_eq("rd_addr17", o_read_data, 0);
      for (int a = 0; a < 5; a++) begin
         rd(a);
         check_eq("rd_burst_valid", o_read_valid, 1);
      end
      level_ups(5);
      check_eq("score_sat", o_Score, SMAX);

      // Randomized play against the reference
      for (int n = 0; n < 4000; n++) begin
         i_All_Switch   = ($urandom_range(0, 39) == 0);
         i_Any_Switch   = i_All_Switch | ($urandom_range(0, 3) == 0);
         i_Has_Collided = ($urandom_range(0, 24) == 0);
         i_Level_Up     = ($urandom_range(0, 5) == 0);
         i_Frame_Tick   = ($urandom_range(0, 1) == 0);
         i_read_en      = ($urandom_range(0, 2) == 0);
         i_read_addr    = 5'($urandom_range(0, 31));
         if (i_read_addr == 5'd4 && m_state != 3) i_read_addr = 5'd1;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
